// File: rtl/reg_bus_pkg.sv
// Shared types and constant helpers for the tri-state register bus reader.
package reg_bus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSelect,
    StResp
  } state_e;

  // Upper bound on register count supported by the idle-mask generator.
  localparam int unsigned MaxRegs = 256;

  // Ceiling log2; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  // Mask with the low n bits set: every register released from the bus.
  function automatic logic [MaxRegs-1:0] cs_idle(input int unsigned n);
    logic [MaxRegs-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MaxRegs; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/bus_select_decoder.sv
// Active-low one-hot decoder driving the per-register tristate controls.
module bus_select_decoder
  import reg_bus_pkg::*;
#(
  parameter int unsigned NrOfRegs = 8,
  parameter int unsigned AW       = 3
) (
  input  logic [AW-1:0]       addr,
  input  logic                enable,
  output logic [NrOfRegs-1:0] cs
);

  localparam logic [NrOfRegs-1:0] CsIdle = NrOfRegs'(cs_idle(NrOfRegs));

  // Pull exactly one control low when enabled; otherwise release the whole bus.
  always_comb begin
    cs = CsIdle;
    if (enable) cs[addr] = 1'b0;
  end

endmodule

// File: rtl/register_bus_reader.sv
// Burst reader for the shared tri-state register bus: selects, settles, samples,
// then hands each word out on a valid/ready response port.
module register_bus_reader
  import reg_bus_pkg::*;
#(
  parameter int unsigned NrOfBits     = 16,
  parameter int unsigned NrOfRegs     = 8,
  parameter int unsigned SettleCycles = 1,
  localparam int unsigned AW          = clog2(NrOfRegs)
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Tick,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [AW-1:0]       req_addr,
  input  logic [AW-1:0]       req_len,
  output logic [NrOfRegs-1:0] cs,
  input  logic [NrOfBits-1:0] bus,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [NrOfBits-1:0] rsp_data,
  output logic [AW-1:0]       rsp_addr,
  output logic                rsp_last,
  output logic                busy
);

  // Settle counter spans 0..SettleCycles inclusive.
  localparam int unsigned SW = clog2(SettleCycles + 2);
  localparam logic [SW-1:0] SettleMax = SW'(SettleCycles);

  state_e        state;
  logic [AW-1:0] cur_addr;
  logic [AW-1:0] remaining;
  logic [SW-1:0] settle_cnt;
  logic          sel_en;

  // Sequence requests through select/settle/sample and response handshake.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= StIdle;
      cur_addr   <= '0;
      remaining  <= '0;
      settle_cnt <= '0;
      rsp_data   <= '0;
      rsp_addr   <= '0;
      rsp_last   <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (req_valid) begin
            cur_addr   <= req_addr;
            remaining  <= req_len;
            settle_cnt <= '0;
            state      <= StSelect;
          end
        end
        StSelect: begin
          if (Tick) begin
            if (settle_cnt == SettleMax) begin
              rsp_data <= bus;
              rsp_addr <= cur_addr;
              rsp_last <= (remaining == '0);
              state    <= StResp;
            end else begin
              settle_cnt <= settle_cnt + SW'(1);
            end
          end
        end
        StResp: begin
          // Passing through RESP (cs released) is what gives break-before-make.
          if (rsp_ready) begin
            if (rsp_last) begin
              state <= StIdle;
            end else begin
              cur_addr   <= cur_addr + AW'(1);
              remaining  <= remaining - AW'(1);
              settle_cnt <= '0;
              state      <= StSelect;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign sel_en    = (state == StSelect);
  assign req_ready = (state == StIdle);
  assign busy      = (state != StIdle);
  assign rsp_valid = (state == StResp);

  bus_select_decoder #(
    .NrOfRegs (NrOfRegs),
    .AW       (AW)
  ) u_decoder (
    .addr   (cur_addr),
    .enable (sel_en),
    .cs     (cs)
  );

endmodule

// File: tb/tb_register_bus_reader.sv
// Randomized self-checking bench for register_bus_reader.
module tb_register_bus_reader;

  logic        Clock;
  logic        Reset;
  logic [15:0] regs [8];
  int          checks;
  int          errors;

  // DUT 1: SettleCycles = 1
  logic        tick, req_valid, req_ready, rsp_valid, rsp_ready, rsp_last, busy;
  logic [2:0]  req_addr, req_len, rsp_addr;
  logic [7:0]  cs;
  logic [15:0] bus, rsp_data;

  // DUT 2: SettleCycles = 2
  logic        tick2, req_valid2, req_ready2, rsp_valid2, rsp_ready2, rsp_last2, busy2;
  logic [2:0]  req_addr2, req_len2, rsp_addr2;
  logic [7:0]  cs2;
  logic [15:0] bus2, rsp_data2;

  register_bus_reader #(
    .NrOfBits     (16),
    .NrOfRegs     (8),
    .SettleCycles (1)
  ) u_dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Tick      (tick),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .cs        (cs),
    .bus       (bus),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_addr  (rsp_addr),
    .rsp_last  (rsp_last),
    .busy      (busy)
  );

  register_bus_reader #(
    .NrOfBits     (16),
    .NrOfRegs     (8),
    .SettleCycles (2)
  ) u_dut2 (
    .Clock     (Clock),
    .Reset     (Reset),
    .Tick      (tick2),
    .req_valid (req_valid2),
    .req_ready (req_ready2),
    .req_addr  (req_addr2),
    .req_len   (req_len2),
    .cs        (cs2),
    .bus       (bus2),
    .rsp_valid (rsp_valid2),
    .rsp_ready (rsp_ready2),
    .rsp_data  (rsp_data2),
    .rsp_addr  (rsp_addr2),
    .rsp_last  (rsp_last2),
    .busy      (busy2)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Register bank model: a selected register drives its value, otherwise junk.
  always_comb begin
    bus = 16'hF00D;
    for (int i = 0; i < 8; i++) if (!cs[i]) bus = regs[i];
  end
  always_comb begin
    bus2 = 16'hF00D;
    for (int i = 0; i < 8; i++) if (!cs2[i]) bus2 = regs[i];
  end

  // Bus-contention watch: never two drivers, always a released cycle between registers.
  logic [7:0] prev_cs = 8'hFF;
  always @(negedge Clock) begin
    checks++;
    if ($countones(~cs) > 1) begin
      errors++;
      $display("FAIL cs_onehot cs=%b required at most one low bit", cs);
    end
    checks++;
    if (prev_cs != 8'hFF && cs != 8'hFF && cs != prev_cs) begin
      errors++;
      $display("FAIL break_before_make cs=%b prev=%b required all-ones gap", cs, prev_cs);
    end
    prev_cs = cs;
  end

  task automatic fill_regs();
    for (int i = 0; i < 8; i++) regs[i] = 16'($urandom) | 16'h0001;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    @(negedge Clock);
    @(negedge Clock);
    checks++; if (cs !== 8'hFF) begin errors++; $display("FAIL rst_cs got=%b req=11111111", cs); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got=%b req=0", rsp_valid); end
    checks++; if (rsp_last !== 1'b0) begin errors++; $display("FAIL rst_rsp_last got=%b req=0", rsp_last); end
    checks++; if (rsp_data !== 16'h0) begin errors++; $display("FAIL rst_rsp_data got=%h req=0000", rsp_data); end
    checks++; if (rsp_addr !== 3'd0) begin errors++; $display("FAIL rst_rsp_addr got=%0d req=0", rsp_addr); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got=%b req=1", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b req=0", busy); end
    checks++; if (cs2 !== 8'hFF || busy2 !== 1'b0) begin
      errors++; $display("FAIL rst_dut2 got cs=%b busy=%b req cs=11111111 busy=0", cs2, busy2);
    end
    Reset = 1'b0;
  endtask

  task automatic test_single();
    fill_regs();
    regs[3] = 16'hBEEF;
    tick = 1'b1; rsp_ready = 1'b1;
    req_addr = 3'd3; req_len = 3'd0; req_valid = 1'b1;
    @(negedge Clock);
    req_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (cs !== 8'b11110111) begin
        errors++; $display("FAIL single_cs_cycle%0d got=%b req=11110111", c, cs);
      end
      @(negedge Clock);
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'hBEEF || rsp_addr !== 3'd3 || rsp_last !== 1'b1) begin
      errors++;
      $display("FAIL single_rsp got v=%b d=%h a=%0d l=%b req v=1 d=beef a=3 l=1",
               rsp_valid, rsp_data, rsp_addr, rsp_last);
    end
    @(negedge Clock);
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL single_idle got busy=%b ready=%b req busy=0 ready=1", busy, req_ready);
    end
    rsp_ready = 1'b0;
  endtask

  // First burst is the fixed wrap case; the rest are random with random backpressure.
  task automatic test_bursts();
    logic [2:0] a, l, ea;
    int n, idx, cyc;
    for (int b = 0; b < 12; b++) begin
      fill_regs();
      if (b == 0) begin
        a = 3'd6; l = 3'd3;
        regs[6] = 16'h0006; regs[7] = 16'h0007; regs[0] = 16'h0000; regs[1] = 16'h0001;
      end else begin
        a = 3'($urandom); l = 3'($urandom);
      end
      n = int'(l) + 1;
      tick = 1'b1; req_addr = a; req_len = l; req_valid = 1'b1;
      @(negedge Clock);
      req_valid = 1'b0;
      idx = 0; cyc = 0;
      while (idx < n && cyc < 500) begin
        rsp_ready = (b == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
        if (rsp_valid) begin
          ea = a + 3'(idx);
          checks++;
          if (rsp_addr !== ea || rsp_data !== regs[ea] || rsp_last !== (idx == n - 1) ||
              cs !== 8'hFF) begin
            errors++;
            $display("FAIL burst%0d_word%0d got a=%0d d=%h l=%b cs=%b req a=%0d d=%h l=%b cs=ff",
                     b, idx, rsp_addr, rsp_data, rsp_last, cs, ea, regs[ea], (idx == n - 1));
          end
          if (rsp_ready) idx++;
        end
        @(negedge Clock);
        cyc++;
      end
      checks++;
      if (idx != n) begin errors++; $display("FAIL burst%0d_count got=%0d req=%0d", b, idx, n); end
      if (b == 0) begin
        checks++;
        if (cyc != n * 3) begin
          errors++; $display("FAIL burst_throughput got=%0d cycles req=%0d", cyc, n * 3);
        end
      end
      checks++;
      if (busy !== 1'b0 || req_ready !== 1'b1) begin
        errors++; $display("FAIL burst%0d_idle got busy=%b ready=%b req 0/1", b, busy, req_ready);
      end
      rsp_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    logic [2:0] ea;
    int cyc;
    fill_regs();
    tick = 1'b1; req_addr = 3'd2; req_len = 3'd2; req_valid = 1'b1;
    @(negedge Clock);
    req_valid = 1'b0;
    for (int w = 0; w < 3; w++) begin
      ea = 3'd2 + 3'(w);
      rsp_ready = 1'b0; cyc = 0;
      while (!rsp_valid && cyc < 50) begin @(negedge Clock); cyc++; end
      checks++;
      if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_wait%0d got valid=0 req 1", w); end
      if (w == 1) begin
        for (int s = 0; s < 5; s++) begin
          checks++;
          if (rsp_valid !== 1'b1 || rsp_data !== regs[ea] || rsp_addr !== ea || cs !== 8'hFF) begin
            errors++;
            $display("FAIL bp_stall%0d got v=%b d=%h a=%0d cs=%b req v=1 d=%h a=%0d cs=ff",
                     s, rsp_valid, rsp_data, rsp_addr, cs, regs[ea], ea);
          end
          @(negedge Clock);
        end
      end
      rsp_ready = 1'b1;
      checks++;
      if (rsp_data !== regs[ea] || rsp_addr !== ea || rsp_last !== (w == 2)) begin
        errors++;
        $display("FAIL bp_word%0d got d=%h a=%0d l=%b req d=%h a=%0d l=%b",
                 w, rsp_data, rsp_addr, rsp_last, regs[ea], ea, (w == 2));
      end
      @(negedge Clock);
    end
    rsp_ready = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle got busy=%b req 0", busy); end
  endtask

  task automatic test_tick_gating();
    logic [2:0] a;
    logic [7:0] exp_cs;
    int ticks, cyc;
    fill_regs();
    a = 3'($urandom);
    exp_cs = 8'hFF;
    exp_cs[a] = 1'b0;
    tick2 = 1'b0; rsp_ready2 = 1'b0;
    req_addr2 = a; req_len2 = 3'd0; req_valid2 = 1'b1;
    @(negedge Clock);
    req_valid2 = 1'b0;
    ticks = 0; cyc = 0;
    while (!rsp_valid2 && cyc < 100) begin
      checks++;
      if (cs2 !== exp_cs) begin
        errors++; $display("FAIL tick_cs cyc%0d got=%b req=%b", cyc, cs2, exp_cs);
      end
      tick2 = (cyc % 4 == 3);
      if (tick2) ticks++;
      @(negedge Clock);
      cyc++;
    end
    tick2 = 1'b0;
    checks++;
    if (ticks != 3) begin errors++; $display("FAIL tick_edges got=%0d req=3", ticks); end
    checks++;
    if (rsp_valid2 !== 1'b1 || rsp_data2 !== regs[a] || rsp_addr2 !== a || rsp_last2 !== 1'b1) begin
      errors++;
      $display("FAIL tick_rsp got v=%b d=%h a=%0d l=%b req v=1 d=%h a=%0d l=1",
               rsp_valid2, rsp_data2, rsp_addr2, rsp_last2, regs[a], a);
    end
    // Handshake completes with Tick low.
    rsp_ready2 = 1'b1;
    @(negedge Clock);
    rsp_ready2 = 1'b0;
    checks++;
    if (busy2 !== 1'b0) begin errors++; $display("FAIL tick_idle got busy=%b req 0", busy2); end
  endtask

  task automatic test_reset_mid();
    logic [2:0] a;
    int cyc;
    fill_regs();
    a = 3'($urandom);
    tick = 1'b1; rsp_ready = 1'b0;
    req_addr = a; req_len = 3'd2; req_valid = 1'b1;
    @(negedge Clock);
    req_valid = 1'b0;
    checks++;
    if (cs === 8'hFF) begin errors++; $display("FAIL rmid_select got cs=%b req one low bit", cs); end
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    checks++;
    if (cs !== 8'hFF || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rmid_sel_reset got cs=%b v=%b rdy=%b req cs=ff v=0 rdy=1", cs, rsp_valid, req_ready);
    end
    req_valid = 1'b1;
    @(negedge Clock);
    req_valid = 1'b0;
    cyc = 0;
    while (!rsp_valid && cyc < 50) begin @(negedge Clock); cyc++; end
    checks++;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rmid_wait got valid=0 req 1"); end
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    checks++;
    if (cs !== 8'hFF || rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_data !== 16'h0 ||
        rsp_addr !== 3'd0 || rsp_last !== 1'b0) begin
      errors++;
      $display("FAIL rmid_resp_reset got cs=%b v=%b rdy=%b d=%h a=%0d l=%b req ff/0/1/0000/0/0",
               cs, rsp_valid, req_ready, rsp_data, rsp_addr, rsp_last);
    end
    a = a + 3'd5;
    req_addr = a; req_len = 3'd0; req_valid = 1'b1; rsp_ready = 1'b1;
    @(negedge Clock);
    req_valid = 1'b0;
    cyc = 0;
    while (!rsp_valid && cyc < 50) begin @(negedge Clock); cyc++; end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== regs[a] || rsp_addr !== a || rsp_last !== 1'b1) begin
      errors++;
      $display("FAIL rmid_after got v=%b d=%h a=%0d l=%b req v=1 d=%h a=%0d l=1",
               rsp_valid, rsp_data, rsp_addr, rsp_last, regs[a], a);
    end
    @(negedge Clock);
    rsp_ready = 1'b0;
  endtask

  task automatic test_busy_request();
    logic [2:0] a, ea;
    int words, cyc;
    fill_regs();
    a = 3'($urandom);
    tick = 1'b1; rsp_ready = 1'b1;
    req_addr = a; req_len = 3'd1; req_valid = 1'b1;
    @(negedge Clock);
    req_addr = a + 3'd4; req_len = 3'd3;
    @(negedge Clock);
    req_valid = 1'b0;
    words = 0; cyc = 0;
    while (busy && cyc < 100) begin
      if (rsp_valid) begin
        ea = a + 3'(words);
        checks++;
        if (rsp_data !== regs[ea] || rsp_addr !== ea || rsp_last !== (words == 1)) begin
          errors++;
          $display("FAIL busyreq_word%0d got d=%h a=%0d l=%b req d=%h a=%0d l=%b",
                   words, rsp_data, rsp_addr, rsp_last, regs[ea], ea, (words == 1));
        end
        words++;
      end
      @(negedge Clock);
      cyc++;
    end
    checks++;
    if (words != 2) begin errors++; $display("FAIL busyreq_count got=%0d req=2", words); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
        errors++; $display("FAIL busyreq_quiet got busy=%b v=%b req 0/0", busy, rsp_valid);
      end
      @(negedge Clock);
    end
    rsp_ready = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    Reset = 1'b1;
    tick = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0; rsp_ready = 1'b0;
    tick2 = 1'b0; req_valid2 = 1'b0; req_addr2 = '0; req_len2 = '0; rsp_ready2 = 1'b0;
    for (int i = 0; i < 8; i++) regs[i] = 16'h0;
    repeat (2) @(negedge Clock);
    test_reset();
    test_single();
    test_bursts();
    test_backpressure();
    test_tick_gating();
    test_reset_mid();
    test_busy_request();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_bus_reader.md
# register_bus_reader

Bus-side reader for the shared tri-state register bus. It selects one register at a time via its active-high tristate control (`cs`, where 1 means the output is high-Z), waits a settle interval, samples the bus, and returns each word on a valid/ready response port. Burst requests read consecutive registers with wrap-around. It sits between the CPU datapath's read port and the bank of tri-stated registers.

## Interface
Parameters:
- `NrOfBits`, 16: bus and register data width.
- `NrOfRegs`, 8: number of registers on the bus; power of two, ≥2.
- `SettleCycles`, 1: Tick-qualified cycles cs is held low before sampling; ≥0.
- `AW` (local): log2(NrOfRegs).

Ports:
- Clock: reset is synchronous and active-high, on `Clock` and `Reset`.
- `Clock`, in, 1: sole clock; all state updates on rising edge.
- `Reset`, in, 1: synchronous, active-high.
- `Tick`, in, 1: advance enable for select/settle timing.
- `req_valid`, in, 1: burst read request.
- `req_ready`, out, 1: high only in IDLE.
- `req_addr`, in, AW: first register index.
- `req_len`, in, AW: burst length minus 1 (0 means 1 word; all-ones means NrOfRegs words).
- `cs`, out, NrOfRegs: per-register tristate control; bit i=0 means register i drives the bus; all-ones means idle.
- `bus`, in, NrOfBits: shared register bus.
- `rsp_valid`, out, 1: response word available.
- `rsp_ready`, in, 1: consumer accepts.
- `rsp_data`, out, NrOfBits: captured word.
- `rsp_addr`, out, AW: index the word came from.
- `rsp_last`, out, 1: final word of burst.
- `busy`, out, 1: state ≠ IDLE.

## Operation
- States: IDLE, SELECT, RESP.
- IDLE: `req_ready`=1. On `req_valid`&`req_ready`, latch addr into `cur_addr` and len into `remaining`, clear `settle_cnt`, and go to SELECT. Tick is not required to accept.
- SELECT: `cs[cur_addr]`=0 and all other bits are 1. On a Tick edge:
  - If `settle_cnt`==SettleCycles, capture `bus` into `rsp_data`, set `rsp_addr`=`cur_addr`, set `rsp_last`=(`remaining`==0), and go to RESP.
  - Otherwise, increment `settle_cnt`.
  - Non-Tick edges hold state.
- RESP: `cs` is all-ones and `rsp_valid`=1. `rsp_data`, `rsp_addr` and `rsp_last` are stable until the handshake. On `rsp_valid`&`rsp_ready`, independent of Tick:
  - If `rsp_last`, go to IDLE.
  - Otherwise, set `cur_addr`=(`cur_addr`+1) mod NrOfRegs, decrement `remaining`, clear `settle_cnt`, and go to SELECT.
- Break-before-make: at most one `cs` bit is low at any time, with at least one all-ones cycle between consecutive registers. This is guaranteed by RESP.
- Address arithmetic is AW bits wide and wraps naturally; a burst of NrOfRegs words starting at k ends at k-1.
- `req_valid` while busy is ignored (`req_ready`=0); no queueing.

## Timing
- Reset values: state IDLE, `cs` all-ones, `rsp_valid`=0, `rsp_last`=0, `rsp_data`=0, `rsp_addr`=0, `req_ready`=1, `busy`=0.
- Reset mid-operation: the next edge forces reset values. A pending response is dropped and `cs` is released the same edge.
- Latency with Tick held at 1: accept edge E0. `cs` goes low after E0, the bus is sampled at edge E(SettleCycles+1), and `rsp_valid` is visible the cycle after. Latency is SettleCycles+1 cycles.
- Burst throughput with `rsp_ready`=1 and Tick=1: one word per SettleCycles+2 cycles.
- The bus is sampled only while the selected `cs` bit is low, on the edge leaving SELECT.
- Tick low stalls SELECT indefinitely, with `cs` held. RESP handshakes still complete.

## Structure
- Shared package `reg_bus_pkg`:
  - state enum (IDLE/SELECT/RESP);
  - `clog2` helper for AW;
  - `CS_IDLE` all-ones constant generator.
- Natural sub-module: `bus_select_decoder`, a combinational active-low one-hot decoder from (`cur_addr`, enable) to `cs`. Everything else stays in the top FSM.

## Test plan
- Single read: reg 3 drives 0xBEEF, req addr=3 len=0, Tick=1, SettleCycles=1. Expect `cs`=0b11110111 for 2 cycles, then `rsp_valid` with data 0xBEEF, `rsp_addr`=3, `rsp_last`=1, then IDLE.
- Wrap burst: addr=6 len=3 with regs holding 0x0006/0x0007/0x0000/0x0001. Expect words in order addrs 6,7,0,1 with `rsp_last` only on addr 1. Expect ≥1 all-ones `cs` cycle between selects and never two `cs` bits low.
- Backpressure: `rsp_ready`=0 for 5 cycles mid-burst. `rsp_valid`, data and addr must stay stable, and `cs` must stay all-ones throughout.
- Tick gating: Tick pulses every 4th cycle, SettleCycles=2. SELECT lasts 3 Tick edges, the bus is sampled on the 3rd, and the response is correct.
- Reset in SELECT and in RESP: on the next edge, `cs` is all-ones, `rsp_valid`=0 and `req_ready`=1. A new request afterward completes normally.
- Request while busy: `req_valid` pulsed during SELECT is ignored, and the in-flight burst length is unchanged.
